fpu_unit_arbiter: RTL and testbench
===================================

// Module: fpu_unit_arbiter
// PURPOSE
//  Shares one MulFPU_FSM and one AddSubFPU_FSM between NREQ requesters, e.g. DivFPU_FSM Newton-Raphson steps and core FPU issue.
//  Per unit: accepts op requests, registers the operands, pulses the unit start, waits for done, and routes the result to the owner.
//  Mul and add/sub run concurrently for different requesters; each unit has its own round-robin arbitration.
// PARAMETERS
//  NREQ  2  number of requesters (legal 2..4)
// PORTS
//  clk          in   1        clock; all logic rising-edge
//  rst          in   1        synchronous, active-high reset
//  req_valid    in   NREQ     request i pending; held with op/operands until req_ready[i]
//  req_op       in   2*NREQ   per req: 00 mul, 01 add, 10 sub, 11 illegal
//  req_a        in   32*NREQ  operand A per requester (IEEE-754 single)
//  req_b        in   32*NREQ  operand B per requester
//  req_ready    out  NREQ     1-cycle accept pulse for requester i
//  rsp_valid    out  NREQ     1-cycle result pulse for requester i
//  rsp_data     out  32*NREQ  result for requester i, valid with rsp_valid[i]
//  mul_start    out  1        1-cycle start to MulFPU_FSM
//  mul_a/mul_b  out  32 each  registered operands to multiplier
//  mul_done     in   1        multiplier completion pulse
//  mul_result   in   32       multiplier result, valid with mul_done
//  add_start    out  1        1-cycle start to AddSubFPU_FSM
//  add_a/add_b  out  32 each  registered operands to adder
//  add_sel      out  1        0 add, 1 subtract; held through operation
//  add_done     in   1        adder completion pulse
//  add_result   in   32       adder result, valid with add_done
// BEHAVIOUR
//  Reset: all outputs 0; both unit FSMs IDLE; both RR pointers = requester 0; owner/outstanding flags cleared.
//  Outstanding rule: max one op in flight per requester. req_valid[i] is ignored while i is outstanding.
//  Per-unit FSM (MUL, ADD), states IDLE -> START -> WAIT -> RESP -> IDLE:
//   IDLE: candidates = valid, not outstanding, op targets this unit (00 mul; 01/10 add).
//     Grant the first candidate at or after the RR pointer. In the same cycle pulse req_ready[g],
//     register a/b (and add_sel = op[1]), record owner g, set outstanding[g]. Next state START.
//   START: unit start=1 for exactly one cycle -> WAIT.
//   WAIT: hold operands/sel; on unit done register result -> RESP. Done seen in IDLE/START is ignored.
//   RESP: rsp_valid[owner]=1 and rsp_data[owner]=result for one cycle; clear outstanding[owner];
//     RR pointer = owner+1 mod NREQ -> IDLE. A new grant is possible in the next cycle.
//  Latency: grant at T, start at T+1; unit done at T+1+L gives rsp_valid at T+2+L. Throughput: one op per unit per L+3 cycles.
//  Cross-unit conflict: in one cycle both units may grant different requesters. If both could pick the same requester,
//   the requester can only target one unit by op, so no conflict is possible.
//  Illegal op 11: accepted when no unit FSM is granting that requester in the same cycle (ready pulse), no unit started;
//   rsp_valid with 32'h7FC00000 (canonical qNaN) exactly 1 cycle later.
//  Simultaneous responses to different requesters (mul RESP + add RESP, or + illegal) are all delivered the same cycle.
//  rsp_data[i] holds its last value between pulses.
//  Reset mid-operation: all state is dropped, and no rsp_valid is ever issued for the aborted op.
//   Shared units share rst, so no stale done can arrive.
// TESTING
//  1 Single mul: req0 op00 a=3F800000(1.0) b=40000000(2.0) -> req_ready0 at T, mul_start at T+1, rsp_valid0 data=40000000 at done+1.
//  2 Contention: req0 and req1 both op01 in the same cycle after reset -> req0 granted first; req1 granted the cycle after req0's RESP;
//     third request pair -> req1 granted (RR pointer advanced).
//  3 Concurrency: req0 op00 1.5*2.0 and req1 op10 2.0-0.5 in the same cycle -> both ready at T, mul/add run in parallel,
//     results 40400000 and 3FC00000 routed to the correct ports.
//  4 Outstanding block: req0 keeps valid high after ready with a new op -> no second ready until rsp_valid0; the next grant follows RESP.
//  5 Illegal op: req1 op11 -> ready, rsp_valid1 next cycle with 7FC00000; mul_start/add_start stay 0.
//  6 Reset in WAIT: assert rst 1 cycle during an add -> all outputs 0 next cycle, no rsp_valid; a fresh request completes normally.

Source files
------------

// File: rtl/fpu_unit_arbiter.sv
// Round-robin sharing of one multiplier and one add/sub unit between NREQ requesters.
// Each unit runs its own IDLE/START/WAIT/RESP sequence; illegal ops are answered with a qNaN.
module fpu_unit_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [32*NREQ-1:0]   rsp_data,
  output logic                 mul_start,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic                 mul_done,
  input  logic [31:0]          mul_result,
  output logic                 add_start,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  output logic                 add_sel,
  input  logic                 add_done,
  input  logic [31:0]          add_result
);
  localparam int PW = $clog2(NREQ);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_e;

  // Unit 0 is the multiplier, unit 1 the add/sub unit.
  state_e          u_state [2];
  logic [PW-1:0]   u_owner [2];
  logic [PW-1:0]   u_gidx  [2];
  logic [31:0]     u_a     [2];
  logic [31:0]     u_b     [2];
  logic [31:0]     u_res   [2];
  logic [1:0]      u_grant;
  logic [1:0]      u_start;
  logic [1:0]      u_done;
  logic [NREQ-1:0] outstanding;
  logic [NREQ-1:0] ill_w;
  logic            add_sel_q;
  logic            add_sel_d;

  assign u_done   = {add_done, mul_done};
  assign u_res[0] = mul_result;
  assign u_res[1] = add_result;

  for (genvar gi = 0; gi < 2; gi++) begin : g_unit
    state_e        state_q;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] owner_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic          start_q;
    logic          grant;
    logic [PW-1:0] gidx;
    logic [31:0]   sel_a;
    logic [31:0]   sel_b;

    // Pick the candidate with the smallest distance from the round-robin pointer.
    always_comb begin
      int best;
      int rank;
      logic [1:0] op;
      logic hit;
      grant = 1'b0;
      gidx  = '0;
      sel_a = '0;
      sel_b = '0;
      best  = NREQ;
      rank  = 0;
      op    = '0;
      hit   = 1'b0;
      if (!rst && state_q == IDLE) begin
        for (int j = 0; j < NREQ; j++) begin
          op   = req_op[2*j +: 2];
          hit  = (gi == 0) ? (op == 2'b00) : (op == 2'b01 || op == 2'b10);
          rank = j - int'(ptr_q);
          if (rank < 0) rank = rank + NREQ;
          if (hit && req_valid[j] && !outstanding[j] && rank < best) begin
            best  = rank;
            grant = 1'b1;
            gidx  = PW'(j);
            sel_a = req_a[32*j +: 32];
            sel_b = req_b[32*j +: 32];
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        ptr_q   <= '0;
        owner_q <= '0;
        a_q     <= '0;
        b_q     <= '0;
        start_q <= 1'b0;
      end else begin
        start_q <= 1'b0;
        case (state_q)
          IDLE: if (grant) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            owner_q <= gidx;
            start_q <= 1'b1;
            state_q <= START;
          end
          START: state_q <= WAIT;
          WAIT:  if (u_done[gi]) state_q <= RESP;
          RESP: begin
            ptr_q   <= (int'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign u_state[gi] = state_q;
    assign u_owner[gi] = owner_q;
    assign u_gidx[gi]  = gidx;
    assign u_grant[gi] = grant;
    assign u_start[gi] = start_q;
    assign u_a[gi]     = a_q;
    assign u_b[gi]     = b_q;
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    logic [1:0]  op;
    logic        ill_acc;
    logic        ill_q;
    logic [31:0] data_q;
    logic [1:0]  own;
    logic [1:0]  fin;

    assign op  = req_op[2*gi +: 2];
    assign own = {u_state[1] != IDLE && u_owner[1] == PW'(gi),
                  u_state[0] != IDLE && u_owner[0] == PW'(gi)};
    // fin marks the unit whose result for this requester is being captured.
    assign fin = {u_state[1] == WAIT && u_done[1] && u_owner[1] == PW'(gi),
                  u_state[0] == WAIT && u_done[0] && u_owner[0] == PW'(gi)};

    assign outstanding[gi] = ill_q | (|own);
    assign ill_acc         = !rst && req_valid[gi] && op == 2'b11 && !outstanding[gi];
    assign ill_w[gi]       = ill_q;
    assign req_ready[gi]   = ill_acc | (u_grant[0] && u_gidx[0] == PW'(gi))
                                     | (u_grant[1] && u_gidx[1] == PW'(gi));
    assign rsp_valid[gi]   = ill_q | (own[0] && u_state[0] == RESP) | (own[1] && u_state[1] == RESP);
    assign rsp_data[32*gi +: 32] = data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        ill_q  <= 1'b0;
        data_q <= '0;
      end else begin
        ill_q <= ill_acc;
        if (ill_acc)     data_q <= QNAN;
        else if (fin[0]) data_q <= u_res[0];
        else if (fin[1]) data_q <= u_res[1];
      end
    end
  end

  always_comb begin
    add_sel_d = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (u_gidx[1] == PW'(j)) add_sel_d = req_op[2*j+1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)             add_sel_q <= 1'b0;
    else if (u_grant[1]) add_sel_q <= add_sel_d;
  end

  assign mul_start = u_start[0];
  assign mul_a     = u_a[0];
  assign mul_b     = u_b[0];
  assign add_start = u_start[1];
  assign add_a     = u_a[1];
  assign add_b     = u_b[1];
  assign add_sel   = add_sel_q;
endmodule

// File: tb/tb_fpu_unit_arbiter.sv
// Bench for fpu_unit_arbiter: behavioural unit stubs plus a timestamp-based model of
// grants, responses and round-robin order; directed scenarios followed by random traffic.
module tb_fpu_unit_arbiter;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_op;
  logic [32*N-1:0] req_a, req_b;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [32*N-1:0] rsp_data;
  logic           mul_start, mul_done, add_start, add_done, add_sel;
  logic [31:0]    mul_a, mul_b, mul_result, add_a, add_b, add_result;

  always #5 clk = ~clk;

  fpu_unit_arbiter #(.NREQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result),
    .add_start(add_start), .add_a(add_a), .add_b(add_b), .add_sel(add_sel),
    .add_done(add_done), .add_result(add_result)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  // Model: per unit the owner, grant cycle and done cycle; per requester the illegal accept cycle.
  bit          u_busy [2];
  int          u_owner [2], u_tg [2], u_td [2], u_lat [2], u_ptr [2];
  logic [31:0] u_ea [2], u_eb [2], u_res [2];
  logic        u_sub;
  int          ill_t [N];
  logic [31:0] exp_data [N];
  int          fixed_lat;
  bit          stray_en;

  logic [N-1:0]    obs_ready, obs_rv;
  logic            obs_ms, obs_as;
  logic [32*N-1:0] obs_data;
  int              obs_cyc;
  int              cnt_ready [N];
  int              cnt_rsp;
  int              cnt_start;

  logic [31:0] ftab [8] = '{32'h3F000000, 32'h3F800000, 32'h3FC00000, 32'h40000000,
                            32'h40200000, 32'h40400000, 32'h40800000, 32'h3E800000};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    real m;
    int  e;
    if (f[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(int'(f[22:0])) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic s;
    int   e;
    real  m;
    logic [22:0] man;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    man = 23'($rtoi((m - 1.0) * 8388608.0));
    return {s, 8'(e), man};
  endfunction

  function automatic logic [31:0] fpop(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return r2f(f2r(a) * f2r(b));
      2'b01:   return r2f(f2r(a) + f2r(b));
      2'b10:   return r2f(f2r(a) - f2r(b));
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      u_busy[u] = 0; u_ptr[u] = 0; u_owner[u] = 0; u_tg[u] = -10; u_td[u] = -1;
    end
    for (int i = 0; i < N; i++) begin
      ill_t[i] = -10; exp_data[i] = 32'h0;
    end
  endtask

  task automatic set_req(input int i, input bit v, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]      = v;
    req_op[2*i +: 2]  = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  // One clock cycle: called just after a falling edge with inputs set, returns after the next one.
  task automatic step();
    logic [N-1:0] outst, exp_ready, exp_rv, ill_new;
    bit           gv [2];
    int           gsel [2];
    bit           resp [2];
    logic         exp_st [2];
    logic [1:0]   op;
    bit           hit;
    int           j;
    mul_done = 1'b0;
    add_done = 1'b0;
    for (int u = 0; u < 2; u++) begin
      bit d;
      logic [31:0] r;
      d = 0;
      r = $urandom;
      if (u_busy[u] && u_td[u] < 0 && cyc == u_tg[u] + 1 + u_lat[u]) begin
        d = 1;
        u_td[u] = cyc;
        if (u == 0) r = r2f(f2r(mul_a) * f2r(mul_b));
        else        r = r2f(add_sel ? f2r(add_a) - f2r(add_b) : f2r(add_a) + f2r(add_b));
      end else if (stray_en && (!u_busy[u] || cyc == u_tg[u] + 1) && $urandom_range(7) == 0) begin
        d = 1;
      end
      if (u == 0) begin mul_done = d; mul_result = r; end
      else        begin add_done = d; add_result = r; end
    end
    #1;
    for (int i = 0; i < N; i++)
      outst[i] = (ill_t[i] == cyc - 1) || (u_busy[0] && u_owner[0] == i) || (u_busy[1] && u_owner[1] == i);
    exp_ready = '0;
    ill_new   = '0;
    for (int u = 0; u < 2; u++) begin
      gv[u] = 0;
      gsel[u] = 0;
      if (!u_busy[u]) begin
        for (int k = 0; k < N; k++) begin
          j   = (u_ptr[u] + k) % N;
          op  = req_op[2*j +: 2];
          hit = (u == 0) ? (op == 2'b00) : (op == 2'b01 || op == 2'b10);
          if (!gv[u] && hit && req_valid[j] && !outst[j]) begin
            gv[u] = 1; gsel[u] = j; exp_ready[j] = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_op[2*i +: 2] == 2'b11 && !outst[i]) begin
        exp_ready[i] = 1'b1; ill_new[i] = 1'b1;
      end
    end
    exp_rv = '0;
    for (int i = 0; i < N; i++) begin
      if (ill_t[i] == cyc - 1) begin exp_rv[i] = 1'b1; exp_data[i] = 32'h7FC00000; end
    end
    for (int u = 0; u < 2; u++) begin
      resp[u]   = u_busy[u] && u_td[u] >= 0 && cyc == u_td[u] + 1;
      exp_st[u] = u_busy[u] && cyc == u_tg[u] + 1;
      if (resp[u]) begin exp_rv[u_owner[u]] = 1'b1; exp_data[u_owner[u]] = u_res[u]; end
    end

    check_eq("req_ready", req_ready, exp_ready);
    check_eq("rsp_valid", rsp_valid, exp_rv);
    for (int i = 0; i < N; i++)
      check_eq($sformatf("rsp_data%0d", i), rsp_data[32*i +: 32], exp_data[i]);
    check_eq("mul_start", mul_start, exp_st[0]);
    check_eq("add_start", add_start, exp_st[1]);
    if (u_busy[0] && cyc > u_tg[0]) check_eq("mul_ops", {mul_a, mul_b}, {u_ea[0], u_eb[0]});
    if (u_busy[1] && cyc > u_tg[1]) begin
      check_eq("add_ops", {add_a, add_b}, {u_ea[1], u_eb[1]});
      check_eq("add_sel", add_sel, u_sub);
    end
    for (int i = 0; i < N; i++) begin
      if (rsp_valid[i]) $display("cycle %0d rsp req%0d data=%08h", cyc, i, rsp_data[32*i +: 32]);
      if (req_ready[i]) cnt_ready[i]++;
    end
    if (rsp_valid != '0) cnt_rsp++;
    if (mul_start || add_start) cnt_start++;
    obs_ready = req_ready; obs_rv = rsp_valid; obs_ms = mul_start; obs_as = add_start;
    obs_data  = rsp_data;  obs_cyc = cyc;

    for (int u = 0; u < 2; u++) begin
      if (resp[u]) begin u_busy[u] = 0; u_ptr[u] = (u_owner[u] + 1) % N; end
    end
    for (int u = 0; u < 2; u++) begin
      if (gv[u]) begin
        u_busy[u] = 1; u_owner[u] = gsel[u]; u_tg[u] = cyc; u_td[u] = -1;
        u_lat[u]  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
        u_ea[u]   = req_a[32*gsel[u] +: 32];
        u_eb[u]   = req_b[32*gsel[u] +: 32];
        op        = req_op[2*gsel[u] +: 2];
        u_res[u]  = fpop(op, u_ea[u], u_eb[u]);
        if (u == 1) u_sub = (op == 2'b10);
      end
    end
    for (int i = 0; i < N; i++) if (ill_new[i]) ill_t[i] = cyc;
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_for(input bit on_rsp, input logic [N-1:0] mask, input string tag, output int t);
    t = -1;
    for (int n = 0; n < 40; n++) begin
      step();
      if (((on_rsp ? obs_rv : obs_ready) & mask) != '0) begin
        t = obs_cyc;
        break;
      end
    end
    check_eq({tag, "_seen"}, 64'(t >= 0), 64'd1);
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_valid = '0; mul_done = 1'b0; add_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc++;
  endtask

  initial begin
    int t, r, t2, c0;
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    mul_done = 1'b0; add_done = 1'b0; mul_result = '0; add_result = '0;
    stray_en = 0; fixed_lat = 3; cyc = 0; cnt_rsp = 0; cnt_start = 0;
    for (int i = 0; i < N; i++) cnt_ready[i] = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step();
    check_eq("reset_out", {obs_ready, obs_rv, obs_ms, obs_as}, 64'd0);
    check_eq("reset_data", obs_data, 64'd0);

    // Single multiply, latency 3
    set_req(0, 1, 2'b00, 32'h3F800000, 32'h40000000);
    wait_for(0, 3'b001, "t1_ready", t);
    set_req(0, 0, 2'b00, 0, 0);
    wait_for(1, 3'b001, "t1_rsp", r);
    check_eq("t1_latency", r - t, 5);
    check_eq("t1_data", obs_data[31:0], 32'h40000000);

    // Contention on the adder, then round-robin on the multiplier
    set_req(0, 1, 2'b01, 32'h3F800000, 32'h3F800000);
    set_req(1, 1, 2'b01, 32'h40000000, 32'h3F800000);
    wait_for(0, 3'b011, "t2_ready", t);
    check_eq("t2_first", obs_ready, 3'b001);
    set_req(0, 0, 2'b00, 0, 0);
    wait_for(1, 3'b001, "t2_rsp0", r);
    wait_for(0, 3'b010, "t2_ready1", t2);
    check_eq("t2_next", t2 - r, 1);
    set_req(1, 0, 2'b00, 0, 0);
    wait_for(1, 3'b010, "t2_rsp1", r);
    check_eq("t2_data1", obs_data[63:32], 32'h40400000);
    set_req(0, 1, 2'b00, 32'h40000000, 32'h40000000);
    set_req(1, 1, 2'b00, 32'h40400000, 32'h40000000);
    wait_for(0, 3'b011, "t2_pair", t);
    check_eq("t2_rr", obs_ready, 3'b010);
    set_req(1, 0, 2'b00, 0, 0);
    wait_for(0, 3'b001, "t2_pair0", t);
    set_req(0, 0, 2'b00, 0, 0);
    repeat (12) step();

    // Multiplier and subtractor in parallel
    fixed_lat = 2;
    set_req(0, 1, 2'b00, 32'h3FC00000, 32'h40000000);
    set_req(1, 1, 2'b10, 32'h40000000, 32'h3F000000);
    wait_for(0, 3'b011, "t3_ready", t);
    check_eq("t3_both", obs_ready, 3'b011);
    set_req(0, 0, 2'b00, 0, 0);
    set_req(1, 0, 2'b00, 0, 0);
    wait_for(1, 3'b011, "t3_rsp", r);
    check_eq("t3_rv", obs_rv, 3'b011);
    check_eq("t3_mul", obs_data[31:0], 32'h40400000);
    check_eq("t3_sub", obs_data[63:32], 32'h3FC00000);

    // Outstanding block: valid stays high with a new op after the first accept
    fixed_lat = 4;
    set_req(0, 1, 2'b00, 32'h40000000, 32'h40800000);
    wait_for(0, 3'b001, "t4_ready", t);
    c0 = cnt_ready[0];
    set_req(0, 1, 2'b01, 32'h3F800000, 32'h3F000000);
    wait_for(1, 3'b001, "t4_rsp", r);
    check_eq("t4_block", cnt_ready[0] - c0, 0);
    check_eq("t4_data", obs_data[31:0], 32'h41000000);
    wait_for(0, 3'b001, "t4_ready2", t2);
    check_eq("t4_after", t2 - r, 1);
    set_req(0, 0, 2'b00, 0, 0);
    repeat (10) step();

    // Illegal op
    c0 = cnt_start;
    set_req(1, 1, 2'b11, 32'h3F800000, 32'h3F800000);
    wait_for(0, 3'b010, "t5_ready", t);
    set_req(1, 0, 2'b00, 0, 0);
    step();
    check_eq("t5_rv", obs_rv, 3'b010);
    check_eq("t5_data", obs_data[63:32], 32'h7FC00000);
    step();
    check_eq("t5_nostart", cnt_start - c0, 0);

    // Reset while the adder is waiting
    fixed_lat = 8;
    set_req(0, 1, 2'b01, 32'h3F800000, 32'h40000000);
    wait_for(0, 3'b001, "t6_ready", t);
    set_req(0, 0, 2'b00, 0, 0);
    repeat (3) step();
    apply_reset();
    step();
    check_eq("t6_out", {obs_ready, obs_rv, obs_ms, obs_as}, 64'd0);
    check_eq("t6_data", obs_data, 64'd0);
    c0 = cnt_rsp;
    repeat (12) step();
    check_eq("t6_norsp", cnt_rsp - c0, 0);
    fixed_lat = 2;
    set_req(0, 1, 2'b01, 32'h3F800000, 32'h3F800000);
    wait_for(0, 3'b001, "t6_fresh", t);
    set_req(0, 0, 2'b00, 0, 0);
    wait_for(1, 3'b001, "t6_rsp", r);
    check_eq("t6_result", obs_data[31:0], 32'h40000000);

    // Random traffic with random latencies and stray done pulses
    fixed_lat = 0;
    stray_en  = 1;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        if ((req_valid[i] && obs_ready[i]) || !req_valid[i]) begin
          if ((req_valid[i] && $urandom_range(1) == 0) || (!req_valid[i] && $urandom_range(2) == 0))
            set_req(i, 1, 2'($urandom_range(3)), ftab[$urandom_range(7)], ftab[$urandom_range(7)]);
          else
            set_req(i, 0, 2'b00, 0, 0);
        end
      end
      step();
    end
    req_valid = '0;
    repeat (15) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
